averager_controller: RTL and testbench

Sequencer that drives the averager counter through repeated acquisitions on behalf of the host register bank. It latches the frame period, dwells a programmed number of clock-enable cycles per acquisition, requests the end-of-average via `restart`, then waits for `ready` and captures `n_avg`. It repeats this for N acquisitions or continuously, and reports progress and a timeout fault.

---
 rtl/averager_controller_pkg.sv | 19 +
 rtl/averager_controller_if.sv | 32 +++
 rtl/averager_controller_watchdog.sv | 31 +++
 rtl/averager_controller.sv | 174 +++++++++++++++++
 tb/tb_averager_controller.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/averager_controller_pkg.sv
// Shared types and default widths for the averager sequencer.
// Optional watchdog: AVERAGER_CONTROLLER_TIMEOUT_EN.
package averager_ctrl_pkg;

    localparam int FAST_W  = 13;
    localparam int SLOW_W  = 19;
    localparam int DWELL_W = 32;
    localparam int ACQ_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACCUM,
        RESTART,
        DRAIN,
        CAPTURE
    } state_t;

endpackage

// File: rtl/averager_controller_if.sv
// Link between the sequencer (master) and the averager (slave).
// Optional watchdog: AVERAGER_CONTROLLER_TIMEOUT_EN.
interface averager_controller_if
    import averager_ctrl_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = FAST_W,
    parameter int SLOW_COUNT_WIDTH = SLOW_W
);

    logic                        restart;
    logic [FAST_COUNT_WIDTH-1:0] count_max;
    logic                        avg_on;
    logic                        ready;
    logic [SLOW_COUNT_WIDTH-1:0] n_avg;

    modport master (
        output restart,
        output count_max,
        output avg_on,
        input  ready,
        input  n_avg
    );

    modport slave (
        input  restart,
        input  count_max,
        input  avg_on,
        output ready,
        output n_avg
    );

endinterface

// File: rtl/averager_controller_watchdog.sv
// Loadable down-counter flagging a stalled restart/drain handshake.
// Built only with AVERAGER_CONTROLLER_TIMEOUT_EN.
`ifdef AVERAGER_CONTROLLER_TIMEOUT_EN
module averager_watchdog #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    // A zero load never reaches one, so it disables the check.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= load_val;
        end else if (enable && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expired = enable && !clear && (cnt == WIDTH'(1));

endmodule
`endif

// File: rtl/averager_controller.sv
// Acquisition sequencer driving the averager restart/ready handshake.
// Optional watchdog: AVERAGER_CONTROLLER_TIMEOUT_EN.
module averager_controller
    import averager_ctrl_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = FAST_W,
    parameter int SLOW_COUNT_WIDTH = SLOW_W,
    parameter int DWELL_WIDTH      = DWELL_W
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic                        stop,
    input  logic [FAST_COUNT_WIDTH-1:0] cfg_period,
    input  logic [DWELL_WIDTH-1:0]      cfg_dwell,
    input  logic [ACQ_W-1:0]            cfg_n_acq,
    input  logic                        cfg_avg_on,
    input  logic [DWELL_WIDTH-1:0]      cfg_timeout,
    input  logic                        clken,
    averager_controller_if.master       av,
    output logic                        busy,
    output logic                        done,
    output logic [ACQ_W-1:0]            acq_count,
    output logic [SLOW_COUNT_WIDTH-1:0] last_n_avg,
    output logic                        timeout_err
);

    state_t state;
    state_t nxt;

    logic [DWELL_WIDTH-1:0]      dwell_cnt;
    logic [DWELL_WIDTH-1:0]      dwell_eff;
    logic                        dwell_hit;
    logic [ACQ_W-1:0]            n_acq_q;
    logic [ACQ_W-1:0]            acq_cnt;
    logic                        acq_hit;
    logic                        last_run;
    logic                        run_go;
    logic                        wd_exp;
    logic                        restart_q;
    logic                        restart_d;
    logic                        busy_q;
    logic                        busy_d;
    logic                        done_q;
    logic                        done_d;
    logic [FAST_COUNT_WIDTH-1:0] count_max_q;
    logic                        avg_on_q;
    logic [SLOW_COUNT_WIDTH-1:0] last_q;

    assign dwell_eff = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
    assign dwell_hit = clken && (dwell_cnt == dwell_eff - DWELL_WIDTH'(1));
    assign acq_hit   = (n_acq_q != '0) && (acq_cnt == n_acq_q);
    assign run_go    = (state == IDLE) && start && !stop;

`ifdef AVERAGER_CONTROLLER_TIMEOUT_EN
    logic wd_en;
    logic terr_q;

    assign wd_en = (state == RESTART) || (state == DRAIN);

    averager_watchdog #(
        .WIDTH (DWELL_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .aresetn  (aresetn),
        .clear    (!wd_en),
        .enable   (wd_en),
        .load_val (cfg_timeout),
        .expired  (wd_exp)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            terr_q <= 1'b0;
        end else if (run_go) begin
            terr_q <= 1'b0;
        end else if (wd_exp) begin
            terr_q <= 1'b1;
        end
    end

    assign timeout_err = terr_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^cfg_timeout;
    assign wd_exp         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (run_go) nxt = ARM;
            ARM:     if (av.ready) nxt = ACCUM;
            ACCUM:   if (stop || dwell_hit) nxt = RESTART;
            RESTART: begin
                if (wd_exp) nxt = IDLE;
                else if (!av.ready) nxt = DRAIN;
            end
            DRAIN: begin
                if (wd_exp) nxt = IDLE;
                else if (av.ready) nxt = CAPTURE;
            end
            CAPTURE: begin
                if (last_run || stop || acq_hit) nxt = IDLE;
                else nxt = ACCUM;
            end
            default: nxt = IDLE;
        endcase
    end

    // busy lags the IDLE exit by one cycle but drops with the IDLE entry.
    always_comb begin
        restart_d = (nxt == RESTART);
        done_d    = (nxt == CAPTURE);
        busy_d    = (state != IDLE) && (nxt != IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            restart_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_max_q <= '1;
            avg_on_q    <= 1'b0;
            n_acq_q     <= '0;
            acq_cnt     <= '0;
            last_q      <= '0;
            last_run    <= 1'b0;
            dwell_cnt   <= '0;
        end else begin
            restart_q <= restart_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (run_go) begin
                count_max_q <= cfg_period;
                avg_on_q    <= cfg_avg_on;
                n_acq_q     <= cfg_n_acq;
                acq_cnt     <= '0;
                last_run    <= 1'b0;
            end
            if (stop && state != IDLE && state != ARM) begin
                last_run <= 1'b1;
            end
            if (state == ARM || state == CAPTURE) begin
                dwell_cnt <= '0;
            end else if (state == ACCUM && clken) begin
                dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
            end
            if (state == DRAIN && nxt == CAPTURE) begin
                last_q  <= av.n_avg;
                acq_cnt <= acq_cnt + ACQ_W'(1);
            end
        end
    end

    assign av.restart   = restart_q;
    assign av.count_max = count_max_q;
    assign av.avg_on    = avg_on_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign acq_count    = acq_cnt;
    assign last_n_avg   = last_q;

endmodule

// File: tb/tb_averager_controller.sv
// Directed bench for averager_controller with an averager handshake model.
// Watchdog steps run only with AVERAGER_CONTROLLER_TIMEOUT_EN.
module tb_averager_controller;

    logic        clk;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [12:0] cfg_period;
    logic [31:0] cfg_dwell;
    logic [15:0] cfg_n_acq;
    logic        cfg_avg_on;
    logic [31:0] cfg_timeout;
    logic        clken;
    logic        busy;
    logic        done;
    logic [15:0] acq_count;
    logic [18:0] last_n_avg;
    logic        timeout_err;

    averager_controller_if #(
        .FAST_COUNT_WIDTH (13),
        .SLOW_COUNT_WIDTH (19)
    ) avif ();

    averager_controller dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start       (start),
        .stop        (stop),
        .cfg_period  (cfg_period),
        .cfg_dwell   (cfg_dwell),
        .cfg_n_acq   (cfg_n_acq),
        .cfg_avg_on  (cfg_avg_on),
        .cfg_timeout (cfg_timeout),
        .clken       (clken),
        .av          (avif),
        .busy        (busy),
        .done        (done),
        .acq_count   (acq_count),
        .last_n_avg  (last_n_avg),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [15:0] acq;
        logic [18:0] nav;
    } exp_t;

    exp_t sbq[$];

    int errs   = 0;
    int checks = 0;

    bit          model_en  = 0;
    bit          force_rdy = 1;
    logic [18:0] nav_val   = '0;
    int          drain     = 0;

    int rs_cnt  = 0;
    int dn_cnt  = 0;
    bit rs_prev = 0;
    bit dn_prev = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    // Averager model: drops ready when restart is seen, drains 3 cycles.
    always @(negedge clk) begin
        avif.n_avg = nav_val;
        if (!model_en) begin
            avif.ready = force_rdy;
        end else if (avif.ready === 1'b1 && avif.restart === 1'b1) begin
            avif.ready = 1'b0;
            drain = 3;
        end else if (avif.ready !== 1'b1) begin
            if (drain > 0) drain--;
            if (drain == 0) avif.ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (avif.restart === 1'b1 && !rs_prev) rs_cnt++;
        if (done === 1'b1 && !dn_prev) dn_cnt++;
        rs_prev = (avif.restart === 1'b1);
        dn_prev = (done === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input logic [18:0] nav);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            e.acq = 16'(i);
            e.nav = nav;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 32'(done), 32'd1);
        if (done === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_acq"}, 32'(acq_count), 32'(e.acq));
            chk({tag, "_nav"}, 32'(last_n_avg), 32'(e.nav));
        end
    endtask

    task automatic wait_restart(input string tag);
        int n;
        n = 0;
        while (avif.restart !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(avif.restart), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int rs0;
        int dn0;
        aresetn     = 0;
        start       = 0;
        stop        = 0;
        cfg_period  = 13'h123;
        cfg_dwell   = 100;
        cfg_n_acq   = 3;
        cfg_avg_on  = 1;
        cfg_timeout = 0;
        clken       = 1;
        force_rdy   = 0;

        repeat (3) @(negedge clk);
        chk("rst_restart", 32'(avif.restart), 0);
        chk("rst_count_max", 32'(avif.count_max), 32'h1FFF);
        chk("rst_avg_on", 32'(avif.avg_on), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_acq", 32'(acq_count), 0);
        chk("rst_last", 32'(last_n_avg), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        aresetn = 1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Run A: ready held low in ARM, then 3 acquisitions of dwell 100.
        nav_val = 19'h2A;
        push(3, 19'h2A);
        rs0 = rs_cnt;
        dn0 = dn_cnt;
        pulse_start();
        chk("busy_edge0", 32'(busy), 0);
        @(negedge clk);
        chk("busy_edge1", 32'(busy), 1);
        repeat (20) @(negedge clk);
        chk("arm_hold_restart", 32'(rs_cnt - rs0), 0);
        chk("arm_busy", 32'(busy), 1);
        chk("latch_count_max", 32'(avif.count_max), 32'h123);
        chk("latch_avg_on", 32'(avif.avg_on), 1);
        cfg_period = 13'h055;
        cfg_avg_on = 0;
        model_en   = 1;
        for (int i = 0; i < 3; i++) wait_done(400, "runA");
        chk("runA_count_max", 32'(avif.count_max), 32'h123);
        chk("runA_avg_on", 32'(avif.avg_on), 1);
        @(negedge clk);
        chk("runA_busy_end", 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk("runA_restarts", 32'(rs_cnt - rs0), 3);
        chk("runA_dones", 32'(dn_cnt - dn0), 3);
        chk("runA_idle", 32'(busy), 0);

        // Run C: clken 1-in-4, dwell 10.
        clken      = 0;
        cfg_dwell  = 10;
        cfg_n_acq  = 1;
        cfg_period = 13'h0AA;
        nav_val    = 19'h07;
        push(1, 19'h07);
        pulse_start();
        @(negedge clk);
        chk("runC_count_max", 32'(avif.count_max), 32'h0AA);
        rs0 = rs_cnt;
        for (int e = 1; e <= 10; e++) begin
            repeat (3) @(negedge clk);
            if (e == 10) chk("runC_rs_before", 32'(avif.restart), 0);
            clken = 1;
            @(negedge clk);
            clken = 0;
        end
        chk("runC_rs_after", 32'(avif.restart), 1);
        chk("runC_rs_once", 32'(rs_cnt - rs0), 0);
        wait_done(50, "runC");

        // Dwell 0 behaves as dwell 1.
        repeat (3) @(negedge clk);
        clken     = 1;
        cfg_dwell = 0;
        nav_val   = 19'h15;
        push(1, 19'h15);
        pulse_start();
        @(negedge clk);
        chk("dw0_rs_n2", 32'(avif.restart), 0);
        @(negedge clk);
        chk("dw0_rs_n3", 32'(avif.restart), 1);
        wait_done(50, "dw0");

        // Continuous run stopped during the 5th acquisition.
        repeat (3) @(negedge clk);
        cfg_dwell = 20;
        cfg_n_acq = 0;
        nav_val   = 19'h33;
        push(5, 19'h33);
        dn0 = dn_cnt;
        pulse_start();
        wait_done(100, "cont1");
        wait_done(100, "cont2");
        repeat (4) @(negedge clk);
        pulse_start();
        wait_done(100, "cont3");
        wait_done(100, "cont4");
        repeat (5) @(negedge clk);
        stop = 1;
        @(negedge clk);
        stop = 0;
        chk("stop_restart", 32'(avif.restart), 1);
        wait_done(50, "cont5");
        @(negedge clk);
        chk("stop_busy", 32'(busy), 0);
        repeat (30) @(negedge clk);
        chk("stop_dones", 32'(dn_cnt - dn0), 5);
        chk("stop_idle", 32'(busy), 0);

        // start and stop together are ignored.
        start = 1;
        stop  = 1;
        @(negedge clk);
        start = 0;
        stop  = 0;
        repeat (3) @(negedge clk);
        chk("ss_busy", 32'(busy), 0);
        chk("ss_restart", 32'(avif.restart), 0);
        chk("ss_acq", 32'(acq_count), 5);

        // ready stuck high with watchdog off: stays in RESTART, then async reset.
        model_en    = 0;
        force_rdy   = 1;
        cfg_timeout = 0;
        cfg_dwell   = 5;
        cfg_n_acq   = 1;
        dn0 = dn_cnt;
        pulse_start();
        wait_restart("stuck_rs_rise");
        repeat (100) @(negedge clk);
        chk("stuck_restart", 32'(avif.restart), 1);
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_nodone", 32'(dn_cnt - dn0), 0);
        chk("stuck_terr", 32'(timeout_err), 0);
        #2 aresetn = 0;
        #1;
        chk("arst_restart", 32'(avif.restart), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count_max", 32'(avif.count_max), 32'h1FFF);
        chk("arst_acq", 32'(acq_count), 0);
        @(negedge clk);
        aresetn = 1;
        repeat (2) @(negedge clk);

`ifdef AVERAGER_CONTROLLER_TIMEOUT_EN
        cfg_timeout = 50;
        dn0 = dn_cnt;
        pulse_start();
        wait_restart("wd_rs_rise");
        repeat (49) @(negedge clk);
        chk("wd_terr_49", 32'(timeout_err), 0);
        chk("wd_rs_49", 32'(avif.restart), 1);
        @(negedge clk);
        chk("wd_terr_50", 32'(timeout_err), 1);
        chk("wd_rs_50", 32'(avif.restart), 0);
        chk("wd_busy_50", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("wd_sticky", 32'(timeout_err), 1);
        chk("wd_nodone", 32'(dn_cnt - dn0), 0);
        chk("wd_acq", 32'(acq_count), 0);
        model_en = 1;
        nav_val  = 19'h11;
        push(1, 19'h11);
        pulse_start();
        @(negedge clk);
        chk("wd_clear", 32'(timeout_err), 0);
        wait_done(60, "wd_run");
        chk("wd_terr_ok", 32'(timeout_err), 0);
`endif

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
